line_fill_wb_unit: RTL

LINE_FILL_WB_UNIT -- requirements
Module: line_fill_wb_unit

---
 rtl/line_fill_wb_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/line_fill_wb_unit.sv
// line_fill_wb_unit: sequences 8-word cache line fills and write-backs over a one-word memory port.
// Latency: request-to-Completed = 1 accept cycle + per-word Ack waits + 1 (10 cycles with Ack every cycle).
// Backpressure: each word holds on Mem_* until Mem_Ack; new requests wait in IDLE while a burst or DONE runs.
module line_fill_wb_unit #(
  parameter int CRIT_WORD_FIRST = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         LB_Enable,
  input  logic [31:0]  ReqAddr,
  output logic [255:0] LB_LineData,
  output logic [31:0]  LB_LineAddr,
  output logic         LB_FirstWord,
  output logic         LB_Completed,
  input  logic         LW_Enable,
  input  logic [255:0] WB_LineData,
  input  logic [31:0]  WB_Addr,
  output logic [31:0]  LineWriteBufAddr,
  output logic         LW_Completed,
  output logic         Mem_Req,
  output logic         Mem_RW,
  output logic [31:0]  Mem_Addr,
  output logic [31:0]  Mem_WData,
  input  logic [31:0]  Mem_RData,
  input  logic         Mem_Ack
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WB_BURST   = 3'd1,
    S_WB_DONE    = 3'd2,
    S_FILL_BURST = 3'd3,
    S_FILL_DONE  = 3'd4
  } state_e;

  state_e         state_q;
  logic [2:0]     idx_q;
  logic [2:0]     cnt_q;
  logic [255:0]   wb_line_q;
  logic [255:0]   lb_line_q;
  logic [31:0]    lb_addr_q;
  logic [31:0]    wb_addr_q;
  logic           mem_req_q;
  logic           mem_rw_q;
  logic [31:0]    mem_addr_q;
  logic [31:0]    mem_wdata_q;
  logic           lb_first_q;
  logic           lb_done_q;
  logic           lw_done_q;

  logic [2:0]     idx_d;
  logic [2:0]     cnt_d;
  logic [2:0]     fill_start_d;
  logic           ack_vld;

  // Byte offsets within a word and within the line never address memory.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^{ReqAddr[1:0], WB_Addr[4:0]};

  // Next word index/count and the qualified Ack (only counts while a burst word is outstanding).
  always_comb begin
    idx_d        = idx_q + 3'd1;
    cnt_d        = cnt_q + 3'd1;
    fill_start_d = (CRIT_WORD_FIRST != 0) ? ReqAddr[4:2] : 3'd0;
    ack_vld      = mem_req_q && Mem_Ack &&
                   ((state_q == S_WB_BURST) || (state_q == S_FILL_BURST));
  end

  // Burst FSM with registered memory-port and status outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      wb_line_q   <= '0;
      lb_line_q   <= '0;
      lb_addr_q   <= '0;
      wb_addr_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      lb_first_q  <= 1'b0;
      lb_done_q   <= 1'b0;
      lw_done_q   <= 1'b0;
    end else begin
      lb_first_q <= 1'b0;
      lb_done_q  <= 1'b0;
      lw_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Write-back has priority so a dirty victim leaves before its slot is refilled.
          if (LW_Enable) begin
            state_q     <= S_WB_BURST;
            wb_line_q   <= WB_LineData;
            wb_addr_q   <= {WB_Addr[31:5], 5'b0};
            idx_q       <= 3'd0;
            cnt_q       <= 3'd0;
            mem_req_q   <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= {WB_Addr[31:5], 3'd0, 2'b00};
            mem_wdata_q <= WB_LineData[31:0];
          end else if (LB_Enable) begin
            state_q     <= S_FILL_BURST;
            lb_addr_q   <= {ReqAddr[31:5], 5'b0};
            idx_q       <= fill_start_d;
            cnt_q       <= 3'd0;
            mem_req_q   <= 1'b1;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= {ReqAddr[31:5], fill_start_d, 2'b00};
            mem_wdata_q <= '0;
          end
        end
        S_WB_BURST: begin
          if (ack_vld) begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= {wb_addr_q[31:5], idx_d, 2'b00};
            mem_wdata_q <= wb_line_q[{idx_d, 5'b00000} +: 32];
            if (cnt_q == 3'd7) begin
              mem_req_q <= 1'b0;
              lw_done_q <= 1'b1;
              state_q   <= S_WB_DONE;
            end
          end
        end
        S_FILL_BURST: begin
          if (ack_vld) begin
            lb_line_q[{idx_q, 5'b00000} +: 32] <= Mem_RData;
            lb_first_q <= (cnt_q == 3'd0);
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= {lb_addr_q[31:5], idx_d, 2'b00};
            if (cnt_q == 3'd7) begin
              mem_req_q <= 1'b0;
              lb_done_q <= 1'b1;
              state_q   <= S_FILL_DONE;
            end
          end
        end
        S_WB_DONE, S_FILL_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign LB_LineData      = lb_line_q;
  assign LB_LineAddr      = lb_addr_q;
  assign LB_FirstWord     = lb_first_q;
  assign LB_Completed     = lb_done_q;
  assign LineWriteBufAddr = wb_addr_q;
  assign LW_Completed     = lw_done_q;
  assign Mem_Req          = mem_req_q;
  assign Mem_RW           = mem_rw_q;
  assign Mem_Addr         = mem_addr_q;
  assign Mem_WData        = mem_wdata_q;

endmodule
